// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared types and geometry for the cacheline burst adaptor.
package cacheline_adaptor_pkg;

  localparam int LINE_W_DEF  = 256;
  localparam int BURST_W_DEF = 64;
  localparam int ADDR_W_DEF  = 32;

  // Beats per line and the width of the beat counter that walks them.
  localparam int BEATS      = LINE_W_DEF / BURST_W_DEF;
  localparam int BEAT_IDX_W = $clog2(BEATS);

  // Byte-offset bits inside one line; these are forced to zero on the memory address.
  localparam int LINE_OFS_W = $clog2(LINE_W_DEF / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: cache-side line request signals plus memory-side burst signals.
// slave modport is the adaptor; master modport is the environment (cache + memory).
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one cacheline read/write into a 4-beat burst and
// returns a single-cycle completion pulse. Optional burst watchdog is enabled
// by defining CACHELINE_ADAPTOR_TIMEOUT_EN (adds TIMEOUT_CYCLES and error_o).
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   bus
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  , output logic               error_o
`endif
);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0]     ADDR_MASK = {{(ADDR_W - LINE_OFS_W){1'b1}}, {LINE_OFS_W{1'b0}}};

  state_t                r_state;
  logic [BEAT_IDX_W-1:0] r_k;
  logic [LINE_W-1:0]     r_buf;
  logic [LINE_W-1:0]     r_line;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_read;
  logic                  r_write;
  logic                  r_resp;
  logic [LINE_W-1:0]     w_merged;
  logic                  w_tmo_hit;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  assign error_o   = r_err;
  // Watchdog fires on the last silent cycle before the limit is reached.
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) && !bus.resp_i;
`else
  assign w_tmo_hit = 1'b0;
`endif

  assign bus.line_o    = r_line;
  assign bus.address_o = r_addr;
  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;
  assign bus.resp_o    = r_resp;
  // Write beat is selected straight from the counter so it follows resp_i without a cycle of lag.
  assign bus.burst_o   = r_buf[r_k*BURST_W +: BURST_W];

  // Line buffer with the incoming read beat dropped into slot k.
  always_comb begin
    w_merged = r_buf;
    w_merged[r_k*BURST_W +: BURST_W] = bus.burst_i;
  end

  // Burst FSM: accept in IDLE, count beats in RD/WR, pulse completion in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_buf   <= '0;
      r_line  <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      r_tmo   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_resp <= 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      if ((r_state == RD || r_state == WR) && !bus.resp_i) begin
        r_tmo <= r_tmo + 1'b1;
      end else begin
        r_tmo <= '0;
      end
      if (w_tmo_hit && (r_state == RD || r_state == WR)) begin
        r_err <= 1'b1;
      end
`endif
      case (r_state)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            r_addr  <= bus.address_i & ADDR_MASK;
            r_buf   <= bus.line_i;
            r_k     <= '0;
            // A write takes priority when both requests are raised together.
            r_state <= bus.write_i ? WR : RD;
            r_write <= bus.write_i;
            r_read  <= !bus.write_i;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            r_buf <= w_merged;
            r_k   <= r_k + 1'b1;
            if (r_k == LAST_BEAT) begin
              r_state <= DONE;
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_line  <= w_merged;
            end
          end else if (w_tmo_hit) begin
            r_state <= DONE;
            r_read  <= 1'b0;
            r_resp  <= 1'b1;
            r_line  <= r_buf;
          end
        end
        WR: begin
          if (bus.resp_i) begin
            r_k <= r_k + 1'b1;
            if (r_k == LAST_BEAT) begin
              r_state <= DONE;
              r_write <= 1'b0;
              r_resp  <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state <= DONE;
            r_write <= 1'b0;
            r_resp  <= 1'b1;
            r_line  <= r_buf;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scoreboard bench for cacheline_adaptor. Expected lines and
// write beats are queued when a transaction is launched and popped as the DUT answers.
// Define CACHELINE_ADAPTOR_TIMEOUT_EN to also exercise the watchdog.
module tb_cacheline_adaptor;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic error_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] line_q[$];
  logic [63:0]  beat_q[$];

  cacheline_adaptor_if #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) bus ();

  cacheline_adaptor #(
    .LINE_W(256), .BURST_W(64), .ADDR_W(32)
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    , .error_o(error_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read one line; pat bit i says whether resp_i is high in the i-th burst cycle.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] line_exp,
                          input logic [7:0] pat, input int plen);
    int beat;
    beat = 0;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b0;
    bus.address_i = addr;
    bus.line_i    = '0;
    line_q.push_back(line_exp);
    tick();
    check("rd_req", bus.read_o, 1'b1);
    check("rd_addr", bus.address_o, {addr[31:5], 5'b0});
    for (int i = 0; i < plen; i++) begin
      bus.resp_i  = pat[i];
      bus.burst_i = pat[i] ? line_exp[64*beat +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[i]) beat++;
      tick();
      if (beat < 4) check("rd_busy", {bus.resp_o, bus.read_o}, 2'b01);
    end
    bus.resp_i = 1'b0;
    check("rd_resp", {bus.resp_o, bus.read_o}, 2'b10);
    check("rd_line", bus.line_o, line_q.pop_front());
    $display("read  addr=%h line=%h", addr, bus.line_o);
    bus.read_i = 1'b0;
    tick();
    check("rd_pulse", bus.resp_o, 1'b0);
  endtask

  // Write one line; burst_o is compared against the queued beat every burst cycle.
  task automatic run_write(input logic [255:0] line, input logic [7:0] pat,
                           input int plen, input bit both);
    for (int b = 0; b < 4; b++) beat_q.push_back(line[64*b +: 64]);
    bus.write_i   = 1'b1;
    bus.read_i    = both;
    bus.address_i = 32'h0000_8040;
    bus.line_i    = line;
    tick();
    check("wr_req", {bus.write_o, bus.read_o}, 2'b10);
    for (int i = 0; i < plen; i++) begin
      bus.resp_i = pat[i];
      check("wr_beat", bus.burst_o, beat_q[0]);
      if (pat[i]) void'(beat_q.pop_front());
      tick();
      if (beat_q.size() > 0) check("wr_busy", {bus.resp_o, bus.write_o, bus.read_o}, 3'b010);
    end
    bus.resp_i = 1'b0;
    check("wr_resp", {bus.resp_o, bus.write_o, bus.read_o}, 3'b100);
    $display("write line=%h both=%0d", line, both);
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    tick();
    check("wr_pulse", bus.resp_o, 1'b0);
  endtask

  initial begin
    logic [255:0] l1, l2, l3, l4, l5;
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l2 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    l3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    l4 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    l5 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;

    // Reset state
    #2;
    check("rst_ctl", {bus.read_o, bus.write_o, bus.resp_o}, 3'b000);
    check("rst_addr", bus.address_o, 32'h0);
    check("rst_line", bus.line_o, 256'h0);
    check("rst_burst", bus.burst_o, 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Contiguous read
    run_read(32'h0000_1234, l1, 8'h0F, 4);

    // Stray responses while idle
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stray", {bus.resp_o, bus.read_o, bus.write_o}, 3'b000);
    end
    bus.resp_i = 1'b0;
    check("stray_line", bus.line_o, l1);
    $display("stray resp_i in idle: resp_o=%0d", bus.resp_o);

    // Gapped write: 1,0,1,1,0,1
    run_write(l2, 8'h2D, 6, 1'b0);
    // Simultaneous request: write wins
    run_write(l3, 8'h0F, 4, 1'b1);
    check("line_hold", bus.line_o, l1);

    // Reset after two read beats
    bus.read_i = 1'b1;
    bus.address_i = 32'h0000_2000;
    tick();
    bus.resp_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.burst_i = l5[64*i +: 64];
      tick();
    end
    check("mid_busy", bus.read_o, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst", {bus.read_o, bus.resp_o}, 2'b00);
    check("mid_line", bus.line_o, 256'h0);
    bus.read_i = 1'b0;
    bus.resp_i = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    check("mid_noresp", bus.resp_o, 1'b0);
    $display("reset mid-burst: read_o=%0d resp_o=%0d", bus.read_o, bus.resp_o);

    // Fresh reads after reset: gapped, then back-to-back
    run_read(32'hABCD_EF5F, l4, 8'h55, 7);
    run_read(32'h0000_0020, l5, 8'h0F, 4);

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    check("tmo_err0", error_o, 1'b0);
    bus.read_i = 1'b1;
    bus.address_i = 32'h0000_4000;
    tick();
    for (int i = 0; i < 7; i++) begin
      check("tmo_busy", {bus.resp_o, bus.read_o}, 2'b01);
      tick();
    end
    check("tmo_busy_last", {bus.resp_o, bus.read_o, error_o}, 3'b010);
    tick();
    check("tmo_done", {bus.resp_o, bus.read_o, error_o}, 3'b101);
    bus.read_i = 1'b0;
    tick();
    check("tmo_sticky", {bus.resp_o, bus.read_o, error_o}, 3'b001);
    $display("timeout: error_o=%0d", error_o);
`endif

    check("sb_lines_empty", line_q.size(), 0);
    check("sb_beats_empty", beat_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
